stack_arbiter: RTL and testbench

//  Two-port request/acknowledge arbiter that shares one LIFO stack (push/pop/data_in, data_out/full/empty)

---
 rtl/stack_arbiter_pkg.sv | 15 +
 rtl/stack_arbiter_if.sv | 35 +++
 rtl/stack_arbiter_rr_arb2.sv | 21 ++
 rtl/stack_arbiter.sv | 153 +++++++++++++++
 tb/tb_stack_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_arbiter_pkg.sv
// Shared types and constants for the two-port stack arbiter.
package stack_arbiter_pkg;

  localparam int unsigned Width = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_e;

  localparam logic OpPush = 1'b0;
  localparam logic OpPop  = 1'b1;

endpackage

// File: rtl/stack_arbiter_if.sv
// Requester-side and stack-side signals of the stack arbiter, bundled as one interface.
interface stack_arbiter_if
  import stack_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = Width
) ();

  logic [1:0]       req;
  logic [1:0]       op;
  logic [1:0]       lock;
  logic [WIDTH-1:0] wdata0;
  logic [WIDTH-1:0] wdata1;
  logic [1:0]       ack;
  logic [1:0]       err;
  logic [WIDTH-1:0] rdata;
  logic             stk_push;
  logic             stk_pop;
  logic [WIDTH-1:0] stk_data_in;
  logic [WIDTH-1:0] stk_data_out;
  logic             stk_full;
  logic             stk_empty;

  // Arbiter side.
  modport slave (
    input  req, op, lock, wdata0, wdata1, stk_data_out, stk_full, stk_empty,
    output ack, err, rdata, stk_push, stk_pop, stk_data_in
  );

  // Environment side: requesters plus the stack.
  modport master (
    output req, op, lock, wdata0, wdata1, stk_data_out, stk_full, stk_empty,
    input  ack, err, rdata, stk_push, stk_pop, stk_data_in
  );

endinterface

// File: rtl/stack_arbiter_rr_arb2.sv
// Two-way round-robin picker: with both requesting, rr_ptr_i selects the winner.
module stack_arbiter_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       rr_ptr_i,
  output logic [1:0] gnt_o,
  output logic       gnt_valid_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = rr_ptr_i ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  assign gnt_valid_o = |req_i;

endmodule

// File: rtl/stack_arbiter.sv
// Serialises push/pop requests from two ports onto one LIFO stack, with round-robin and lock.
module stack_arbiter
  import stack_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = Width
) (
  input  logic           clk,
  input  logic           rstN,
  stack_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             lock_valid_q, lock_valid_d;
  logic             lock_owner_q, lock_owner_d;
  logic             gnt_q, gnt_d;
  logic             op_q, op_d;
  logic             err_q, err_d;
  logic             push_q, push_d;
  logic             pop_q, pop_d;
  logic [WIDTH-1:0] data_in_q, data_in_d;

  logic [1:0]       cand;
  logic [1:0]       gnt;
  logic             gnt_valid;
  logic             g;
  logic             g_op;
  logic [WIDTH-1:0] g_wdata;
  logic             reject;
  logic             lock_release;

  logic [1:0]       ack;
  logic [1:0]       err;
  logic [WIDTH-1:0] rdata;

  // While locked only the owner is eligible.
  assign cand = lock_valid_q ? (bus.req & (lock_owner_q ? 2'b10 : 2'b01)) : bus.req;

  stack_arbiter_rr_arb2 u_rr_arb2 (
    .req_i       (cand),
    .rr_ptr_i    (rr_ptr_q),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid)
  );

  assign g            = gnt[1];
  assign g_op         = bus.op[g];
  assign g_wdata      = g ? bus.wdata1 : bus.wdata0;
  assign reject       = ((g_op == OpPush) && bus.stk_full) || ((g_op == OpPop) && bus.stk_empty);
  assign lock_release = lock_valid_q & ~bus.req[lock_owner_q] & ~bus.lock[lock_owner_q];

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!lock_release && gnt_valid) state_d = reject ? StResp : StIssue;
      end
      StIssue: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ack   = 2'b00;
    err   = 2'b00;
    rdata = '0;
    if (state_q == StResp) begin
      ack[gnt_q] = 1'b1;
      err[gnt_q] = err_q;
      if (!err_q && (op_q == OpPop)) rdata = bus.stk_data_out;
    end
  end

  // Strobes and write data default to zero, so they drop on the ISSUE -> RESP edge.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    gnt_d        = gnt_q;
    op_d         = op_q;
    err_d        = err_q;
    push_d       = 1'b0;
    pop_d        = 1'b0;
    data_in_d    = '0;
    unique case (state_q)
      StIdle: begin
        if (lock_release) begin
          lock_valid_d = 1'b0;
        end else if (gnt_valid) begin
          gnt_d = g;
          op_d  = g_op;
          err_d = reject;
          if (!reject) begin
            push_d    = (g_op == OpPush);
            pop_d     = (g_op == OpPop);
            data_in_d = (g_op == OpPush) ? g_wdata : '0;
          end
        end
      end
      StResp: begin
        if (bus.lock[gnt_q]) begin
          lock_valid_d = 1'b1;
          lock_owner_d = gnt_q;
        end else begin
          lock_valid_d = 1'b0;
          rr_ptr_d     = ~gnt_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      rr_ptr_q     <= 1'b0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      gnt_q        <= 1'b0;
      op_q         <= 1'b0;
      err_q        <= 1'b0;
      push_q       <= 1'b0;
      pop_q        <= 1'b0;
      data_in_q    <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      gnt_q        <= gnt_d;
      op_q         <= op_d;
      err_q        <= err_d;
      push_q       <= push_d;
      pop_q        <= pop_d;
      data_in_q    <= data_in_d;
    end
  end

  assign bus.ack         = ack;
  assign bus.err         = err;
  assign bus.rdata       = rdata;
  assign bus.stk_push    = push_q;
  assign bus.stk_pop     = pop_q;
  assign bus.stk_data_in = data_in_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with an 8-deep stack model and an ack scoreboard.
module tb_stack_arbiter;
  import stack_arbiter_pkg::*;

  localparam int unsigned W     = 4;
  localparam int          Depth = 8;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  always #5 clk = ~clk;

  stack_arbiter_if #(.WIDTH(W)) bus ();

  stack_arbiter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  // 8-deep LIFO; data_out updates at the edge that ends a pop.
  logic [W-1:0] mem [Depth];
  int           sp   = 0;
  logic [W-1:0] dout = '0;

  always @(posedge clk) begin
    if (!rstN) begin
      sp   <= 0;
      dout <= '0;
    end else if (bus.stk_push && sp < Depth) begin
      mem[sp] <= bus.stk_data_in;
      sp      <= sp + 1;
    end else if (bus.stk_pop && sp > 0) begin
      dout <= mem[sp-1];
      sp   <= sp - 1;
    end
  end

  assign bus.stk_data_out = dout;
  assign bus.stk_full     = (sp == Depth);
  assign bus.stk_empty    = (sp == 0);

  typedef struct {
    int           port;
    bit           err;
    logic [W-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ack(input int p, input bit e, input logic [W-1:0] rd);
    exp_t x;
    x.port  = p;
    x.err   = e;
    x.rdata = rd;
    exp_q.push_back(x);
  endtask

  // Scoreboard monitor.
  exp_t       mon_e;
  logic [1:0] mon_ack_exp;
  logic [1:0] mon_err_exp;

  always @(negedge clk) begin
    if (bus.ack != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {30'd0, bus.ack}, 32'd0);
      end else begin
        mon_e       = exp_q.pop_front();
        mon_ack_exp = 2'b01 << mon_e.port;
        mon_err_exp = mon_e.err ? mon_ack_exp : 2'b00;
        check("ack_port", {30'd0, bus.ack}, {30'd0, mon_ack_exp});
        check("ack_err", {30'd0, bus.err}, {30'd0, mon_err_exp});
        check("ack_rdata", {28'd0, bus.rdata}, {28'd0, mon_e.rdata});
      end
    end
  end

  // Issue one op on port p; lat > 0 checks ack latency, solo checks the strobes seen.
  task automatic do_op(input int p, input logic o, input logic lk, input logic [W-1:0] d,
                       input int lat, input bit solo);
    int           n      = 0;
    int           pushes = 0;
    int           pops   = 0;
    logic [W-1:0] seen   = '0;
    bus.op[p]   = o;
    bus.lock[p] = lk;
    if (p == 0) bus.wdata0 = d;
    else        bus.wdata1 = d;
    bus.req[p] = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (bus.stk_push) begin
        pushes++;
        seen = bus.stk_data_in;
      end
      if (bus.stk_pop) pops++;
      check("never_both_strobes", {31'd0, bus.stk_push & bus.stk_pop}, 32'd0);
    end while (!bus.ack[p] && n < 40);
    if (!bus.ack[p]) check($sformatf("ack_timeout_p%0d", p), 32'd0, 32'd1);
    if (lat > 0) check($sformatf("latency_p%0d", p), n, lat);
    if (solo) begin
      if (lat == 1) begin
        check("err_no_push", pushes, 0);
        check("err_no_pop", pops, 0);
      end else if (o == OpPush) begin
        check("push_strobes", pushes, 1);
        check("push_data", {28'd0, seen}, {28'd0, d});
        check("push_no_pop", pops, 0);
      end else begin
        check("pop_strobes", pops, 1);
        check("pop_no_push", pushes, 0);
      end
    end
    bus.req[p] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    bus.req    = 2'b00;
    bus.lock   = 2'b00;
    bus.op     = 2'b00;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
    rstN       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_dut();
    check("rst_ack", {30'd0, bus.ack}, 32'd0);
    check("rst_err", {30'd0, bus.err}, 32'd0);
    check("rst_rdata", {28'd0, bus.rdata}, 32'd0);
    check("rst_push", {31'd0, bus.stk_push}, 32'd0);
    check("rst_pop", {31'd0, bus.stk_pop}, 32'd0);
    check("rst_data_in", {28'd0, bus.stk_data_in}, 32'd0);

    // Single push.
    expect_ack(0, 1'b0, 4'h0);
    do_op(0, OpPush, 1'b0, 4'hA, 2, 1'b1);

    // Fill, overflow, pop.
    reset_dut();
    for (int i = 1; i <= 8; i++) begin
      expect_ack(0, 1'b0, 4'h0);
      do_op(0, OpPush, 1'b0, W'(i), 2, 1'b1);
    end
    expect_ack(0, 1'b1, 4'h0);
    do_op(0, OpPush, 1'b0, 4'h9, 1, 1'b1);
    expect_ack(0, 1'b0, 4'h8);
    do_op(0, OpPop, 1'b0, 4'h0, 2, 1'b1);

    // Simultaneous pops; port 1 preloads so the pointer is back at port 0.
    reset_dut();
    expect_ack(1, 1'b0, 4'h0);
    do_op(1, OpPush, 1'b0, 4'h7, 2, 1'b1);
    expect_ack(1, 1'b0, 4'h0);
    do_op(1, OpPush, 1'b0, 4'h8, 2, 1'b1);
    expect_ack(0, 1'b0, 4'h8);
    expect_ack(1, 1'b0, 4'h7);
    fork
      do_op(0, OpPop, 1'b0, 4'h0, 2, 1'b1);
      do_op(1, OpPop, 1'b0, 4'h0, 0, 1'b0);
    join

    // Locked pop-pop-push on port 0 while port 1 waits.
    expect_ack(1, 1'b0, 4'h0);
    do_op(1, OpPush, 1'b0, 4'h5, 2, 1'b1);
    expect_ack(1, 1'b0, 4'h0);
    do_op(1, OpPush, 1'b0, 4'h6, 2, 1'b1);
    expect_ack(0, 1'b0, 4'h6);
    expect_ack(0, 1'b0, 4'h5);
    expect_ack(0, 1'b0, 4'h0);
    expect_ack(1, 1'b0, 4'h3);
    fork
      begin
        do_op(0, OpPop, 1'b1, 4'h0, 2, 1'b1);
        do_op(0, OpPop, 1'b1, 4'h0, 2, 1'b1);
        do_op(0, OpPush, 1'b0, 4'h3, 2, 1'b1);
      end
      do_op(1, OpPop, 1'b0, 4'h0, 0, 1'b0);
    join

    // Underflow on both ports.
    expect_ack(0, 1'b1, 4'h0);
    do_op(0, OpPop, 1'b0, 4'h0, 1, 1'b1);
    expect_ack(1, 1'b1, 4'h0);
    do_op(1, OpPop, 1'b0, 4'h0, 1, 1'b1);

    // Reset during ISSUE aborts the op.
    bus.op[0]   = OpPush;
    bus.lock[0] = 1'b0;
    bus.wdata0  = 4'hB;
    bus.req[0]  = 1'b1;
    @(posedge clk);
    #1;
    check("abort_issue_push", {31'd0, bus.stk_push}, 32'd1);
    rstN       = 1'b0;
    bus.req[0] = 1'b0;
    @(posedge clk);
    #1;
    check("abort_push_cleared", {31'd0, bus.stk_push}, 32'd0);
    check("abort_pop_cleared", {31'd0, bus.stk_pop}, 32'd0);
    check("abort_no_ack", {30'd0, bus.ack}, 32'd0);
    rstN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_still_no_ack", {30'd0, bus.ack}, 32'd0);
    expect_ack(0, 1'b0, 4'h0);
    do_op(0, OpPush, 1'b0, 4'hC, 2, 1'b1);
    expect_ack(0, 1'b0, 4'hC);
    do_op(0, OpPop, 1'b0, 4'h0, 2, 1'b1);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
